// File: rtl/life_pkg.sv
// Shared constants and types for the Game-of-Life grid and its LED scanner.
package life_pkg;

    localparam int GRID_ROWS = 16;
    localparam int GRID_COLS = 16;

    typedef enum logic [1:0] {
        PAUSED       = 2'd0,
        RUNNING      = 2'd1,
        STEP_PENDING = 2'd2
    } scan_mode_t;

    // Counter width that stays legal for a modulus of 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/life_tick_div.sv
// Modulo-N counter; wrap_o pulses in the enabled cycle that returns the count to zero.
module life_tick_div
    import life_pkg::*;
#(
    parameter int N = 8,
    parameter int W = cnt_width(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/life_led_scan.sv
// Row-multiplexed LED scan of a frame-stable grid snapshot, plus the generation-advance strobe.
module life_led_scan
    import life_pkg::*;
#(
    parameter int ROWS           = GRID_ROWS,
    parameter int COLS           = GRID_COLS,
    parameter int REFRESH_DIV    = 2048,
    parameter int BLANK          = 4,
    parameter int FRAMES_PER_GEN = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ROWS*COLS-1:0] health_grid_i,
    input  logic                 run_i,
    input  logic                 step_req_i,
    output logic                 gen_tick_o,
    output logic [ROWS-1:0]      row_sel_o,
    output logic [COLS-1:0]      col_data_o,
    output logic                 frame_start_o,
    output logic [15:0]          gen_count_o
);

    localparam int DW = cnt_width(REFRESH_DIV);
    localparam int RW = cnt_width(ROWS);
    localparam int FW = cnt_width(FRAMES_PER_GEN);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [DW-1:0] BLANK_W  = DW'(BLANK);

    logic                 started_q;
    logic [DW-1:0]        div_cnt;
    logic                 div_wrap;
    logic [DW-1:0]        div_d;
    logic [RW-1:0]        row_cnt_q;
    logic [RW-1:0]        row_cnt_d;
    logic                 frame_end;
    logic [ROWS*COLS-1:0] snap_q;
    logic [ROWS*COLS-1:0] snap_d;
    logic [ROWS-1:0]      row_sel_q;
    logic [ROWS-1:0]      row_sel_d;
    logic [COLS-1:0]      col_data_q;
    logic [COLS-1:0]      col_data_d;
    logic                 frame_start_q;
    logic                 frame_start_d;

    scan_mode_t           mode_q;
    logic                 frame_clr;
    logic                 frame_en;
    logic [FW-1:0]        frame_cnt;
    logic                 frame_wrap;
    logic                 unused_frame_cnt;
    logic                 step_tick;
    logic                 gen_tick_d;
    logic                 gen_tick_q;
    logic [15:0]          gen_count_q;

    // The first edge after reset only primes the output registers for row 0, div 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q <= 1'b0;
        end else begin
            started_q <= 1'b1;
        end
    end

    life_tick_div #(.N(REFRESH_DIV), .W(DW)) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (1'b0),
        .en_i   (started_q),
        .cnt_o  (div_cnt),
        .wrap_o (div_wrap)
    );

    assign div_d     = div_wrap ? '0 : div_cnt + DW'(started_q);
    assign row_cnt_d = div_wrap ? ((row_cnt_q == ROW_LAST) ? '0 : row_cnt_q + 1'b1) : row_cnt_q;
    assign frame_end = div_wrap && (row_cnt_q == ROW_LAST);
    assign snap_d    = frame_end ? health_grid_i : snap_q;

    // Outputs are computed from next-cycle position so they line up with the counters.
    always_comb begin
        row_sel_d     = (div_d < BLANK_W) ? '0 : (ROWS'(1) << row_cnt_d);
        col_data_d    = snap_d[int'(row_cnt_d) * COLS +: COLS];
        frame_start_d = (div_d == '0) && (row_cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt_q     <= '0;
            snap_q        <= '0;
            row_sel_q     <= '0;
            col_data_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            row_cnt_q     <= row_cnt_d;
            snap_q        <= snap_d;
            row_sel_q     <= row_sel_d;
            col_data_q    <= col_data_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign frame_clr = run_i && (mode_q != RUNNING);
    assign frame_en  = run_i && (mode_q == RUNNING) && frame_end;

    life_tick_div #(.N(FRAMES_PER_GEN), .W(FW)) u_frame (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (frame_clr),
        .en_i   (frame_en),
        .cnt_o  (frame_cnt),
        .wrap_o (frame_wrap)
    );

    // Only the frame counter's wrap pulse drives the FSM.
    assign unused_frame_cnt = ^frame_cnt;

    assign step_tick  = (mode_q == STEP_PENDING) && !run_i && frame_end;
    assign gen_tick_d = step_tick || frame_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= PAUSED;
            gen_tick_q  <= 1'b0;
            gen_count_q <= '0;
        end else begin
            unique case (mode_q)
                PAUSED: begin
                    if (run_i) begin
                        mode_q <= RUNNING;
                    end else if (step_req_i) begin
                        mode_q <= STEP_PENDING;
                    end
                end
                STEP_PENDING: begin
                    if (run_i) begin
                        mode_q <= RUNNING;
                    end else if (frame_end) begin
                        mode_q <= PAUSED;
                    end
                end
                RUNNING: begin
                    if (!run_i) begin
                        mode_q <= PAUSED;
                    end
                end
                default: mode_q <= PAUSED;
            endcase
            gen_tick_q  <= gen_tick_d;
            gen_count_q <= gen_count_q + 16'(gen_tick_d);
        end
    end

    assign gen_tick_o    = gen_tick_q;
    assign row_sel_o     = row_sel_q;
    assign col_data_o    = col_data_q;
    assign frame_start_o = frame_start_q;
    assign gen_count_o   = gen_count_q;

endmodule

// File: doc/life_led_scan.md
Name: life_led_scan

Overview:
- Downstream consumer of the per-cell Game-of-Life state machines.
- Snapshots the full grid of cell health bits once per display frame and row-multiplexes the snapshot onto a ROWS x COLS LED matrix.
- Also generates the generation-advance strobe (gen_tick) that gates cell updates, in run or single-step mode.

Parameters:
- ROWS, 16: grid rows, one LED row driver each
- COLS, 16: grid columns
- REFRESH_DIV, 2048: clock cycles each row is displayed (>= BLANK+1)
- BLANK, 4: cycles at the start of each row slot with all rows off (anti-ghosting; < REFRESH_DIV)
- FRAMES_PER_GEN, 8: display frames per generation in run mode (>= 1)

Ports:
- Clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- health_grid  in  ROWS*COLS  cell states; bit r*COLS+c = cell (row r, col c); 1 = alive
- run  in  1  level; 1 = free-running generations
- step_req  in  1  single-cycle request for one generation while paused
- gen_tick  out  1  one-cycle pulse; cells advance on the edge ending this cycle
- row_sel  out  ROWS  one-hot active-high row enable, or all zero during blanking
- col_data  out  COLS  snapshot bits of the selected row; bit c = column c
- frame_start  out  1  one-cycle pulse in the first cycle of row 0
- gen_count  out  16  generations issued; wraps 0xFFFF -> 0

Behaviour:
- Reset (reset low, asynchronous): all of the following clear immediately:
  - div_cnt, row_cnt, frame_cnt = 0
  - snapshot buffer = 0
  - row_sel = 0, col_data = 0, gen_tick = 0, frame_start = 0, gen_count = 0
  - mode = PAUSED
- Reset applies at any point mid-frame. After release, scanning restarts at row 0, div 0.
- div_cnt counts 0..REFRESH_DIV-1, then wraps.
  - On wrap, row_cnt increments, wrapping ROWS-1 -> 0.
- Frame boundary cycle B: div_cnt = REFRESH_DIV-1 and row_cnt = ROWS-1.
  - At the edge ending B, snapshot <= health_grid.
  - The buffer is otherwise held, so a display frame never mixes generations.
- All outputs are registered. In the cycle where div_cnt = d and row_cnt = r:
  - row_sel = 0 when d < BLANK; otherwise row_sel = one-hot(r).
  - col_data = snapshot row r for the whole slot, including blanking.
  - frame_start = 1 iff r = 0 and d = 0.
- Mode FSM (PAUSED, RUNNING, STEP_PENDING). Transitions are evaluated every cycle; gen_tick decisions are taken only at B.
  - PAUSED:
    - run = 1 -> RUNNING, with frame_cnt <= 0.
    - Else step_req = 1 -> STEP_PENDING.
  - STEP_PENDING:
    - At B, assert gen_tick in the next cycle and return to PAUSED.
    - Extra step_req pulses are coalesced (ignored).
    - run = 1 -> RUNNING; the pending step is dropped.
  - RUNNING:
    - run = 0 -> PAUSED at once; frame_cnt is held, no tick.
    - At each B, if frame_cnt = FRAMES_PER_GEN-1: frame_cnt <= 0 and gen_tick pulses in the next cycle. Otherwise frame_cnt increments.
    - step_req is ignored.
- gen_tick:
  - It is high for exactly one cycle: the cycle after B, which is also the frame_start cycle.
  - gen_count increments on the same edge that sets gen_tick.
  - Cells update at the end of the gen_tick cycle; their new state is captured at the next B.
- Simultaneous events:
  - run rising and step_req in the same cycle: run wins.
  - step_req arriving in cycle B itself: enters STEP_PENDING and waits for the following B.

Decomposition:
- Shared package life_pkg:
  - GRID_ROWS and GRID_COLS constants, which are the defaults here and are also used by the grid top.
  - typedef enum scan_mode_t {PAUSED, RUNNING, STEP_PENDING}.
- One sub-module, life_tick_div: a generic modulo-N counter with a wrap pulse. It is instantiated twice:
  - div_cnt -> row_cnt
  - frame_cnt
- The FSM, snapshot buffer and output registers live in life_led_scan.

Test Plan:
All scenarios use ROWS=4, COLS=4, REFRESH_DIV=8, BLANK=2, FRAMES_PER_GEN=2, giving a 32-cycle frame.
1. Reset then release; health_grid=16'hA5C3 held.
   - Frame 0: col_data=0 throughout.
   - From frame 1: row 0 shows 4'h3, row1 4'hC, row2 4'h5, row3 4'hA.
   - row_sel=0 for d=0..1, one-hot for d=2..7.
   - frame_start every 32 cycles.
2. health_grid changes mid-frame (16'hFFFF at cycle 10 of frame 1).
   - Frame 1 continues showing 16'hA5C3.
   - Frame 2 shows all 4'hF.
3. run=1 held.
   - gen_tick pulses once every 64 cycles, each coincident with frame_start.
   - gen_count reads 1, 2, 3 after successive ticks.
4. Paused: three step_req pulses within one frame.
   - Exactly one gen_tick, at the next frame start.
   - None thereafter; gen_count +1.
5. run=1 and step_req in the same cycle from PAUSED.
   - Mode RUNNING; first tick after 2 frames; no extra tick.
6. reset asserted at div=5 of row 2 with row_sel=4'b0100.
   - row_sel, col_data and gen_count go to 0 before the next edge.
   - After release, frame_start occurs on the first clock.
7. gen_count preloaded via a force to 16'hFFFF, run=1.
   - Next gen_tick wraps gen_count to 0.
